// File: rtl/sub_8bit_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package sub_8bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // State enumeration kept as plain constants so older tools can consume it.
    localparam int STATE_W = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sub_8bit_serial_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when a borrow is needed.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_8bit_serial.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and publishes diff/bout together with a one-cycle done pulse.
//
// Handshake: start is sampled on every rising edge but only acts while idle
// (busy=0); a, b and bin are captured on that edge. done is a single-cycle
// strobe, and diff/bout stay valid from that cycle until the next done.
module sub_8bit_serial
    import sub_8bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             fs_d;
    logic             fs_bout;
    logic             last_bit;
    logic [WIDTH-1:0] res_shifted;

    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit    = (cnt_q == CW'(WIDTH - 1));
    // New bit enters at the MSB so the LSB-first stream lands in place.
    assign res_shifted = (res_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bout;
                res_d = res_shifted;
                cnt_d = cnt_q + CW'(1);
                // The result registers only ever see a finished word.
                if (last_bit) begin
                    state_d = ST_DONE;
                    diff_d  = res_shifted;
                    bout_d  = fs_bout;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sub_8bit_serial.sv
// Directed bench for sub_8bit_serial: a reference model feeds an expected
// queue at each accept edge, and a monitor pops it on every done pulse.
module tb_sub_8bit_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic [1:0]   dbg_state;

    logic [W:0]   exp_q[$];
    int           done_cyc_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           done_cnt = 0;

    sub_8bit_serial #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .bin         (bin),
        .busy        (busy),
        .done        (done),
        .diff        (diff),
        .bout        (bout),
        .dbg_state_o (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic binv);
        return {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("done_without_expected", {31'd0, done}, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("bout_diff", {23'd0, bout, diff}, {23'd0, e});
            end
        end
    end

    // Driver: one start pulse, then measure latency to done in negedges.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
        int lat;
        @(negedge clk);
        a = av; b = bv; bin = binv; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(av, bv, binv));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, 32'd9);
        @(negedge clk);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        int s0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_diff", {24'd0, diff}, 32'd0);
        check("reset_bout", {31'd0, bout}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic cases and borrow boundaries
        do_op(8'h50, 8'h20, 1'b0);
        check("diff_0x30_held", {24'd0, diff}, 32'h30);
        do_op(8'h00, 8'h01, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1);
        do_op(8'h80, 8'h7F, 1'b1);
        do_op(8'hA5, 8'h5A, 1'b0);
        do_op(8'h00, 8'h00, 1'b1);

        // Start re-pulsed mid-run must be ignored
        d0 = done_cnt;
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(8'h10, 8'h01, 1'b0));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("single_done_on_restart", done_cnt - d0, 32'd1);
        check("diff_after_ignored_start", {23'd0, bout, diff}, 32'h00F);

        // Reset mid-run aborts without a result update
        do_op(8'h50, 8'h20, 1'b0);
        @(negedge clk);
        a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("diff_hidden_during_run", {24'd0, diff}, 32'h30);
        check("busy_in_run", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_bout", {31'd0, bout}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (14) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 32'd0);
        do_op(8'h33, 8'h11, 1'b1);

        // Start held high: accepts every W+2 cycles
        s0 = done_cyc_q.size();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            bin = 1'($urandom_range(0, 1));
            start = 1'b1;
            if (i % 10 == 0) exp_q.push_back(model(a, b, bin));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("b2b_done_count", done_cyc_q.size() - s0, 32'd3);
        if (done_cyc_q.size() - s0 == 3) begin
            check("b2b_spacing_1", done_cyc_q[s0 + 1] - done_cyc_q[s0], 32'd10);
            check("b2b_spacing_2", done_cyc_q[s0 + 2] - done_cyc_q[s0 + 1], 32'd10);
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
